// File: rtl/averager_pkg.sv
// Shared types and helpers for the accumulating averager control path.
package averager_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRST = 2'd2,
        ACCUM = 2'd3
    } state_t;

    localparam int unsigned ADDR_LSB_DEFAULT = 2;

    // Byte address of an accumulator word: sample index padded with lsb zero bits.
    function automatic logic [63:0] avg_addr(input logic [31:0] fast_count, input int unsigned lsb);
        return 64'(fast_count) << lsb;
    endfunction

endpackage

// File: rtl/averager_frame_counter.sv
// Sample counter with end-of-frame detect and a latched frame length.
// The frame length only changes when the owner pulses latch.
module averager_frame_counter #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clken,
    input  logic             latch,
    input  logic [WIDTH-1:0] count_max,
    output logic [WIDTH-1:0] fast_count,
    output logic             eof_c
);

    logic [WIDTH-1:0] count_max_reg;

    // Last sample of the current frame on a valid sample cycle.
    assign eof_c = clken && (fast_count == count_max_reg);

    // Free-running sample index and frame-length register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fast_count    <= '0;
            count_max_reg <= '1;
        end else if (clken) begin
            fast_count <= eof_c ? '0 : fast_count + WIDTH'(1);
            if (latch) begin
                count_max_reg <= count_max;
            end
        end
    end

endmodule

// File: rtl/averager_counter_v2.sv
// Timing and control generator for the BRAM accumulating averager.
// Optional macro AVERAGER_COUNTER_RUN_CNT_EN adds a 32-bit completed-run counter.
module averager_counter_v2
    import averager_pkg::*;
#(
    parameter int unsigned FAST_COUNT_WIDTH = 13,
    parameter int unsigned SLOW_COUNT_WIDTH = 19,
    parameter int unsigned ADDR_LSB         = ADDR_LSB_DEFAULT
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               clken,
    input  logic                               restart,
    input  logic                               continuous,
    input  logic [FAST_COUNT_WIDTH-1:0]        count_max,
    input  logic [SLOW_COUNT_WIDTH-1:0]        n_avg_max,
    output logic                               init,
    output logic                               wen,
    output logic                               ready,
    output logic [SLOW_COUNT_WIDTH-1:0]        n_avg,
    output logic                               overflow,
`ifdef AVERAGER_COUNTER_RUN_CNT_EN
    output logic [31:0]                        run_count,
`endif
    output logic [FAST_COUNT_WIDTH+ADDR_LSB-1:0] address
);

    localparam int unsigned SW     = SLOW_COUNT_WIDTH;
    localparam int unsigned SW1    = SLOW_COUNT_WIDTH + 1;
    localparam int unsigned ADDR_W = FAST_COUNT_WIDTH + ADDR_LSB;

    state_t                      state, state_n;
    logic [FAST_COUNT_WIDTH-1:0] fast_count;
    logic                        eof_c;
    logic                        latch_c;
    logic                        done_c;
    logic [SW-1:0]               done_cnt;
    logic [SW-1:0]               slow_count, slow_n;
    logic [SW1-1:0]              slow_inc;
    logic                        bounded;
    logic                        ovf_n;
    logic [SW-1:0]               n_avg_n;
    logic                        wen_n, init_n, ready_n;

    averager_frame_counter #(
        .WIDTH (FAST_COUNT_WIDTH)
    ) u_frame (
        .clk        (clk),
        .resetn     (resetn),
        .clken      (clken),
        .latch      (latch_c),
        .count_max  (count_max),
        .fast_count (fast_count),
        .eof_c      (eof_c)
    );

    assign address  = ADDR_W'(avg_addr(32'(fast_count), ADDR_LSB));
    // Extra bit keeps the all-ones + 1 case from aliasing onto n_avg_max == 0.
    assign slow_inc = {1'b0, slow_count} + SW1'(1);
    assign bounded  = (n_avg_max != '0);

    // Next-state, frame counting and output decode.
    always_comb begin
        state_n  = state;
        slow_n   = slow_count;
        ovf_n    = overflow;
        n_avg_n  = n_avg;
        latch_c  = 1'b0;
        done_c   = 1'b0;
        done_cnt = '0;
        if (clken) begin
            case (state)
                IDLE: begin
                    if (restart) begin
                        state_n = ARMED;
                    end
                end
                ARMED: begin
                    if (eof_c) begin
                        latch_c = 1'b1;
                        slow_n  = '0;
                        ovf_n   = 1'b0;
                        state_n = FIRST;
                    end
                end
                FIRST, ACCUM: begin
                    if (restart) begin
                        n_avg_n = slow_count;
                        state_n = ARMED;
                    end else if (eof_c) begin
                        if (state == FIRST) begin
                            slow_n = SW'(1);
                            if (n_avg_max == SW'(1)) begin
                                done_c   = 1'b1;
                                done_cnt = SW'(1);
                            end else begin
                                state_n = ACCUM;
                            end
                        end else if (bounded && (slow_inc == SW1'(n_avg_max))) begin
                            done_c   = 1'b1;
                            done_cnt = slow_inc[SW-1:0];
                        end else if (!bounded && (&slow_count)) begin
                            ovf_n = 1'b1;
                        end else begin
                            slow_n = slow_inc[SW-1:0];
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        if (done_c) begin
            n_avg_n = done_cnt;
            if (continuous) begin
                state_n = FIRST;
                latch_c = 1'b1;
                slow_n  = '0;
                ovf_n   = 1'b0;
            end else begin
                state_n = IDLE;
                slow_n  = done_cnt;
            end
        end
        wen_n   = (state_n == FIRST) || (state_n == ACCUM);
        init_n  = (state_n == FIRST);
        ready_n = (state_n == IDLE);
    end

    // State, slow counter and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            slow_count <= '0;
            overflow   <= 1'b0;
            n_avg      <= '0;
            wen        <= 1'b0;
            init       <= 1'b0;
            ready      <= 1'b1;
        end else begin
            state      <= state_n;
            slow_count <= slow_n;
            overflow   <= ovf_n;
            n_avg      <= n_avg_n;
            wen        <= wen_n;
            init       <= init_n;
            ready      <= ready_n;
        end
    end

`ifdef AVERAGER_COUNTER_RUN_CNT_EN
    // Completed runs only; aborts never reach done_c.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_count <= '0;
        end else if (done_c) begin
            run_count <= run_count + 32'd1;
        end
    end
`endif

endmodule
